sim_run_controller: RTL

Synthesizable run controller for processor-level simulation and FPGA bring-up: sequences core reset, counts cycles and retired instructions, detects test completion via a store to a "tohost" address, and enforces a cycle timeout. Sits beside the pipelined core, snooping its data-memory write port and retire signal. It replaces fixed-delay testbench timing (hard-coded reset pulse and `$finish` after N time units) with a parametrised, self-terminating verdict usable on silicon and in simulation.

---
 rtl/sim_run_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sim_run_controller.sv
// ---------------------------------------------------------------------------
// sim_run_controller
//
// Run controller that sits beside a processor core. It holds the core in
// reset for RESET_CYCLES clocks after reset release, then lets it run while
// counting cycles and retired instructions. The run ends in one of these
// sticky verdicts:
//   - PASS    : the core stores the value 1 to TOHOST_ADDR
//   - FAIL    : the core stores any value other than 0 or 1 to TOHOST_ADDR
//   - TIMEOUT : TIMEOUT_CYCLES run cycles elapse without a verdict
//   - HANG    : PC is unchanged with no retirement for HANG_CYCLES edges
//               (only when RUN_CTRL_HANG_DETECT_EN is defined)
// A store of 0 to TOHOST_ADDR is ignored.
//
// Optional feature macro: RUN_CTRL_HANG_DETECT_EN (hang detection).
// Without the macro, hang_o is tied low and pc_i is not used.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   core_reset   out  reset to the core (high outside RUN)
//   pc_i         in   core fetch PC (hang detection only)
//   retire_i     in   one instruction retired this cycle
//   mem_we_i     in   data-memory write enable
//   mem_addr_i   in   data-memory address
//   mem_wdata_i  in   data-memory write data
//   done_o       out  any terminal state reached
//   pass_o       out  PASS verdict
//   fail_o       out  FAIL verdict
//   timeout_o    out  TIMEOUT verdict
//   hang_o       out  HANG verdict
//   fail_code_o  out  failing tohost value shifted right by one
//   cycle_cnt_o  out  RUN cycles elapsed (saturating)
//   retire_cnt_o out  instructions retired in RUN (saturating)
// ---------------------------------------------------------------------------
module sim_run_controller #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                CNT_W          = 32,
    parameter int                RESET_CYCLES   = 4,
    parameter int                TIMEOUT_CYCLES = 1000,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_0FFC,
    parameter int                HANG_CYCLES    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              core_reset,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              retire_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic              hang_o,
    output logic [DATA_W-1:0] fail_code_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

`ifdef RUN_CTRL_HANG_DETECT_EN
    typedef enum logic [2:0] {HOLD, RUN, PASS, FAIL, TIMEOUT, HANG} state_t;
`else
    typedef enum logic [2:0] {HOLD, RUN, PASS, FAIL, TIMEOUT} state_t;
`endif

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic [DATA_W-1:0]  fail_code_q, fail_code_d;

    logic tohost_hit;
    logic timeout_hit;
    logic hang_hit;

    assign tohost_hit  = mem_we_i && (mem_addr_i == TOHOST_ADDR);
    assign timeout_hit = (cycle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef RUN_CTRL_HANG_DETECT_EN
    localparam int STALL_W = $clog2(HANG_CYCLES + 1);

    logic [ADDR_W-1:0]  pc_prev_q;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               stall_edge;

    // A stall edge is one where the PC did not move and nothing retired.
    assign stall_edge = (pc_i == pc_prev_q) && !retire_i;
    assign hang_hit   = stall_edge && (stall_cnt_q == STALL_W'(HANG_CYCLES - 1));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == RUN) begin
            stall_cnt_d = stall_edge ? stall_cnt_q + STALL_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_prev_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pc_prev_q   <= pc_i;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hang_o = (state_q == HANG);
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
    assign hang_hit  = 1'b0;
    assign hang_o    = 1'b0;
`endif

    // Next-state and counter update.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        fail_code_d  = fail_code_q;
        case (state_q)
            HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The verdict edge itself is still counted.
                if (!(&cycle_cnt_q)) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
                if (retire_i && !(&retire_cnt_q)) begin
                    retire_cnt_d = retire_cnt_q + CNT_W'(1);
                end
                // Tohost verdict beats hang, hang beats timeout.
                if (tohost_hit && (mem_wdata_i == DATA_W'(1))) begin
                    state_d = PASS;
                end else if (tohost_hit && (mem_wdata_i != '0)) begin
                    state_d     = FAIL;
                    fail_code_d = mem_wdata_i >> 1;
`ifdef RUN_CTRL_HANG_DETECT_EN
                end else if (hang_hit) begin
                    state_d = HANG;
`endif
                end else if (timeout_hit) begin
                    state_d = TIMEOUT;
                end
            end
            default: ; // terminal states are sticky, counters frozen
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            fail_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            fail_code_q  <= fail_code_d;
        end
    end

    // Outputs decode straight from registers.
    assign core_reset   = (state_q != RUN);
    assign done_o       = (state_q != RUN) && (state_q != HOLD);
    assign pass_o       = (state_q == PASS);
    assign fail_o       = (state_q == FAIL);
    assign timeout_o    = (state_q == TIMEOUT);
    assign fail_code_o  = fail_code_q;
    assign cycle_cnt_o  = cycle_cnt_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule
